// File: rtl/ann_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and the loader / MAC datapath.
// Latency: none, this file only groups wires.
// Backpressure: mac_ready from the datapath stalls the MAC beat stream.
interface ann_layer_sequencer_if #(
    parameter int CNT_W   = 7,
    parameter int LAYER_W = 3
);
    logic               image_weights_loaded;
    logic               coef_loaded;
    logic               mac_ready;
    logic               abort;
    logic               request_coef;
    logic               reset_accum;
    logic               mac_valid;
    logic [CNT_W-1:0]   mac_index;
    logic [CNT_W-1:0]   max_input;
    logic [LAYER_W-1:0] cur_layer;
    logic               load_next;
    logic               done_processing;
    logic               busy;

    // Loader / datapath side: drives the status inputs, consumes the control outputs.
    modport master (
        output image_weights_loaded, coef_loaded, mac_ready, abort,
        input  request_coef, reset_accum, mac_valid, mac_index, max_input,
               cur_layer, load_next, done_processing, busy
    );

    // Sequencer side.
    modport slave (
        input  image_weights_loaded, coef_loaded, mac_ready, abort,
        output request_coef, reset_accum, mac_valid, mac_index, max_input,
               cur_layer, load_next, done_processing, busy
    );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Multi-layer ANN sequencer: per layer request coefs, clear accums, stream MAC beats, load next.
// Latency: start sampled in IDLE gives request_coef next cycle; a layer of N inputs takes N+4 cycles.
// Backpressure: mac_ready low holds mac_index and stretches RUN; coef_loaded low stretches WAIT_COEF.
module ann_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 7,
    parameter int LAYER_W    = 3,
    parameter logic [NUM_LAYERS*CNT_W-1:0] LAYER_SIZES = {7'd10, 7'd16, 7'd32, 7'd64}
) (
    input  logic                   clk,
    input  logic                   n_rst,
    ann_layer_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_REQ_COEF    = 3'd1,
        S_WAIT_COEF   = 3'd2,
        S_START_LAYER = 3'd3,
        S_RUN         = 3'd4,
        S_NEXT_LAYER  = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    state_t             r_state;
    logic [LAYER_W-1:0] r_cur_layer;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [LAYER_W-1:0] w_layer_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_max_input;
    logic               w_last_beat;

    // Look up the input count of the current layer; unused layer codes read as empty.
    always_comb begin
        w_max_input = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (r_cur_layer == LAYER_W'(l)) begin
                w_max_input = LAYER_SIZES[l*CNT_W +: CNT_W];
            end
        end
    end

    // Only meaningful in RUN, where max_input is known to be non-zero.
    assign w_last_beat = (r_cnt == (w_max_input - CNT_W'(1)));

    // State, layer and input-counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_cur_layer <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_layer <= w_layer_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state logic; abort outside IDLE overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_cur_layer;
        w_cnt_nxt   = r_cnt;
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_layer_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.image_weights_loaded) begin
                        w_state_nxt = S_REQ_COEF;
                    end
                end
                S_REQ_COEF: begin
                    w_state_nxt = S_WAIT_COEF;
                end
                S_WAIT_COEF: begin
                    if (bus.coef_loaded) begin
                        w_state_nxt = S_START_LAYER;
                    end
                end
                S_START_LAYER: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_max_input == '0) ? S_NEXT_LAYER : S_RUN;
                end
                S_RUN: begin
                    if (bus.mac_ready) begin
                        // The final beat leaves the counter at max_input-1 so it never wraps.
                        if (w_last_beat) begin
                            w_state_nxt = S_NEXT_LAYER;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_NEXT_LAYER: begin
                    if (r_cur_layer == LAST_LAYER) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_layer_nxt = r_cur_layer + LAYER_W'(1);
                        w_state_nxt = S_REQ_COEF;
                    end
                end
                S_DONE: begin
                    w_layer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_layer_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode from registers only, so none of them depends on an input this cycle.
    always_comb begin
        bus.request_coef    = (r_state == S_REQ_COEF);
        bus.reset_accum     = (r_state == S_START_LAYER);
        bus.mac_valid       = (r_state == S_RUN);
        bus.load_next       = (r_state == S_NEXT_LAYER);
        bus.done_processing = (r_state == S_DONE);
        bus.busy            = (r_state != S_IDLE);
        bus.mac_index       = r_cnt;
        bus.max_input       = w_max_input;
        bus.cur_layer       = r_cur_layer;
    end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer: default table on instance A, a table with an empty layer on B.
// Cycle c is the period following clock edge c-1; a start sampled at edge 0 shows request_coef in cycle 1.
// Outputs are sampled 1 time unit after the rising edge, inputs driven at that same point.
module tb_ann_layer_sequencer;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    ann_layer_sequencer_if #(.CNT_W(7), .LAYER_W(3)) a_if ();
    ann_layer_sequencer_if #(.CNT_W(7), .LAYER_W(3)) b_if ();

    ann_layer_sequencer #(
        .NUM_LAYERS (4), .CNT_W(7), .LAYER_W(3),
        .LAYER_SIZES({7'd10, 7'd16, 7'd32, 7'd64})
    ) u_dut_a (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (a_if)
    );

    // Layer sizes 4, 0, 2, 3 (layer 0 in the LSBs).
    ann_layer_sequencer #(
        .NUM_LAYERS (4), .CNT_W(7), .LAYER_W(3),
        .LAYER_SIZES({7'd3, 7'd2, 7'd0, 7'd4})
    ) u_dut_b (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (b_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rq[$];
    int lnq[$];
    int sizes[4] = '{64, 32, 16, 10};
    int ln_cnt, dn_cnt, dn_c, xfers, idx_err, exp_idx, exp_layer;
    int x0, low_cnt, hold_err, ln_first;
    int rq0, ra_c, abort_c, post_ln, post_dn;
    int mv1, ra_cnt;

    initial begin
        a_if.image_weights_loaded = 1'b0; a_if.coef_loaded = 1'b0;
        a_if.mac_ready = 1'b0;            a_if.abort = 1'b0;
        b_if.image_weights_loaded = 1'b0; b_if.coef_loaded = 1'b0;
        b_if.mac_ready = 1'b0;            b_if.abort = 1'b0;

        // ---------------- reset ----------------
        #2 n_rst = 1'b0;
        #20;
        chk("rst_busy",      int'(a_if.busy), 0);
        chk("rst_mac_valid", int'(a_if.mac_valid), 0);
        chk("rst_pulses",    int'({a_if.request_coef, a_if.reset_accum,
                                   a_if.load_next, a_if.done_processing}), 0);
        chk("rst_mac_index", int'(a_if.mac_index), 0);
        chk("rst_cur_layer", int'(a_if.cur_layer), 0);
        chk("rst_max_input", int'(a_if.max_input), 64);
        chk("rst_b_max_input", int'(b_if.max_input), 4);
        n_rst = 1'b1;
        tick();

        // ---------------- test 1: inputs high, full run ----------------
        a_if.image_weights_loaded = 1'b1;
        a_if.coef_loaded = 1'b1;
        a_if.mac_ready = 1'b1;
        ln_cnt = 0; dn_cnt = 0; dn_c = -1; xfers = 0; idx_err = 0; exp_idx = 0; exp_layer = 0;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (c == 1) a_if.image_weights_loaded = 1'b0;
            if (a_if.request_coef) rq.push_back(c);
            if (a_if.load_next) ln_cnt++;
            if (a_if.done_processing) begin dn_cnt++; dn_c = c; end
            if (a_if.mac_valid && a_if.mac_ready) begin
                if (int'(a_if.mac_index) != exp_idx || int'(a_if.cur_layer) != exp_layer) idx_err++;
                xfers++;
                exp_idx++;
                if (exp_layer < 4 && exp_idx == sizes[exp_layer]) begin
                    exp_idx = 0;
                    exp_layer++;
                end
            end
            if (c == 140) chk("t1_busy_c140", int'(a_if.busy), 0);
        end
        chk("t1_req_count", rq.size(), 4);
        if (rq.size() == 4) begin
            chk("t1_req0", rq[0], 1);
            chk("t1_req1", rq[1], 69);
            chk("t1_req2", rq[2], 105);
            chk("t1_req3", rq[3], 125);
        end
        chk("t1_load_next", ln_cnt, 4);
        chk("t1_done_count", dn_cnt, 1);
        chk("t1_done_cycle", dn_c, 139);
        chk("t1_transfers", xfers, 122);
        chk("t1_index_err", idx_err, 0);
        chk("t1_layers_swept", exp_layer, 4);

        // ---------------- test 2: mac_ready toggles during layer 0 ----------------
        a_if.image_weights_loaded = 1'b1;
        x0 = 0; low_cnt = 0; hold_err = 0; ln_first = -1; dn_c = -1;
        for (int c = 1; c <= 205; c++) begin
            tick();
            if (c == 1) a_if.image_weights_loaded = 1'b0;
            a_if.mac_ready = (x0 < 64) ? (c % 2 == 0) : 1'b1;
            if (a_if.mac_valid && a_if.cur_layer == 3'd0) begin
                if (int'(a_if.mac_index) != x0) hold_err++;
                if (a_if.mac_ready) x0++;
                else low_cnt++;
            end
            if (a_if.load_next && ln_first < 0) ln_first = c;
            if (a_if.done_processing) dn_c = c;
        end
        a_if.mac_ready = 1'b1;
        chk("t2_l0_transfers", x0, 64);
        chk("t2_index_hold_err", hold_err, 0);
        chk("t2_low_cycles", low_cnt, 63);
        chk("t2_load_next_cycle", ln_first, 131);
        chk("t2_done_cycle", dn_c, 202);

        // ---------------- test 3: coef late, then abort on final beat of layer 2 ----------------
        a_if.image_weights_loaded = 1'b1;
        rq0 = 0; ra_c = -1; abort_c = -1; post_ln = 0; post_dn = 0;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (c == 1) a_if.image_weights_loaded = 1'b0;
            a_if.abort = 1'b0;
            a_if.coef_loaded = !(c >= 2 && c <= 6);
            if (a_if.request_coef && a_if.cur_layer == 3'd0) rq0++;
            if (a_if.reset_accum && ra_c < 0) ra_c = c;
            if (abort_c > 0) begin
                if (a_if.load_next) post_ln++;
                if (a_if.done_processing) post_dn++;
                if (c == abort_c + 1) begin
                    chk("t3_abort_busy", int'(a_if.busy), 0);
                    chk("t3_abort_layer", int'(a_if.cur_layer), 0);
                    chk("t3_abort_index", int'(a_if.mac_index), 0);
                end
                if (c >= abort_c + 4) break;
            end else if (a_if.mac_valid && a_if.cur_layer == 3'd2 && a_if.mac_index == 7'd15) begin
                a_if.abort = 1'b1;
                abort_c = c;
            end
        end
        a_if.abort = 1'b0;
        a_if.coef_loaded = 1'b1;
        chk("t3_req_single", rq0, 1);
        chk("t3_reset_accum_cycle", ra_c, 8);
        chk("t3_abort_cycle", abort_c, 128);
        chk("t3_no_load_next", post_ln, 0);
        chk("t3_no_done", post_dn, 0);

        // abort in IDLE is ignored; start proceeds and completes normally
        a_if.abort = 1'b1;
        a_if.image_weights_loaded = 1'b1;
        tick();
        a_if.abort = 1'b0;
        a_if.image_weights_loaded = 1'b0;
        chk("t3_idle_abort_req", int'(a_if.request_coef), 1);
        chk("t3_idle_abort_layer", int'(a_if.cur_layer), 0);
        ln_cnt = 0; dn_c = -1;
        for (int c = 2; c <= 141; c++) begin
            tick();
            if (a_if.load_next) ln_cnt++;
            if (a_if.done_processing) dn_c = c;
        end
        chk("t3_rerun_load_next", ln_cnt, 4);
        chk("t3_rerun_done_cycle", dn_c, 139);

        // ---------------- test 4: zero-size layer 1 on instance B ----------------
        b_if.image_weights_loaded = 1'b1;
        b_if.coef_loaded = 1'b1;
        b_if.mac_ready = 1'b1;
        mv1 = 0; ra_cnt = 0; xfers = 0; dn_c = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) b_if.image_weights_loaded = 1'b0;
            if (b_if.mac_valid && b_if.cur_layer == 3'd1) mv1++;
            if (b_if.mac_valid && b_if.mac_ready) xfers++;
            if (b_if.reset_accum) ra_cnt++;
            if (b_if.load_next) lnq.push_back(c);
            if (b_if.done_processing) dn_c = c;
        end
        chk("t4_no_valid_layer1", mv1, 0);
        chk("t4_reset_accum_count", ra_cnt, 4);
        chk("t4_load_next_count", lnq.size(), 4);
        if (lnq.size() >= 2) chk("t4_layer1_load_next", lnq[1], 12);
        chk("t4_transfers", xfers, 9);
        chk("t4_done_cycle", dn_c, 26);

        // ---------------- test 5: asynchronous reset mid-RUN ----------------
        a_if.image_weights_loaded = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) a_if.image_weights_loaded = 1'b0;
        end
        chk("t5_pre_layer", int'(a_if.cur_layer), 1);
        chk("t5_pre_index", int'(a_if.mac_index), 8);
        #2 n_rst = 1'b0;
        #1;
        chk("t5_rst_busy", int'(a_if.busy), 0);
        chk("t5_rst_mac_valid", int'(a_if.mac_valid), 0);
        chk("t5_rst_mac_index", int'(a_if.mac_index), 0);
        chk("t5_rst_cur_layer", int'(a_if.cur_layer), 0);
        chk("t5_rst_max_input", int'(a_if.max_input), 64);
        chk("t5_rst_pulses", int'({a_if.request_coef, a_if.reset_accum,
                                   a_if.load_next, a_if.done_processing}), 0);
        #3 n_rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
